tblink_rpc_cmdsender: RTL and testbench

Initiator-side mirror of the command processor's inbound path. It accepts one command from a put/get toggle-index slot and serializes it as a tblink byte packet on a ready/valid output. It then collects the matching response packet from a ready/valid input and presents the response bytes before toggling the get index. It sits between a host-side command source and the tblink_rpc_ep tipi/tipo byte streams.

---
 rtl/tblink_rpc_cmd_pkg.sv | 30 +++
 rtl/tblink_rpc_rsp_deser.sv | 57 +++++
 rtl/tblink_rpc_cmdsender.sv | 182 ++++++++++++++++++
 tb/tb_tblink_rpc_cmdsender.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/tblink_rpc_cmd_pkg.sv
// Shared constants for the tblink RPC command sender: FSM encodings,
// completion status codes, packet header offsets and status merging.
package tblink_rpc_cmd_pkg;

   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_TX_ADDR  = 4'd1;
   localparam logic [3:0] ST_TX_LEN   = 4'd2;
   localparam logic [3:0] ST_TX_CMD   = 4'd3;
   localparam logic [3:0] ST_TX_PARAM = 4'd4;
   localparam logic [3:0] ST_RX_ADDR  = 4'd5;
   localparam logic [3:0] ST_RX_LEN   = 4'd6;
   localparam logic [3:0] ST_RX_CMD   = 4'd7;
   localparam logic [3:0] ST_RX_DATA  = 4'd8;
   localparam logic [3:0] ST_DONE     = 4'd9;

   localparam logic [1:0] STAT_OK       = 2'd0;
   localparam logic [1:0] STAT_OVF      = 2'd1;
   localparam logic [1:0] STAT_MISMATCH = 2'd2;
   localparam logic [1:0] STAT_TIMEOUT  = 2'd3;

   localparam int HDR_ADDR = 0;
   localparam int HDR_LEN  = 1;
   localparam int HDR_CMD  = 2;

   // Status codes are ordered by precedence, so the stronger one is the larger.
   function automatic logic [1:0] stat_merge(input logic [1:0] cur, input logic [1:0] nxt);
      return (nxt > cur) ? nxt : cur;
   endfunction

endpackage

// File: rtl/tblink_rpc_rsp_deser.sv
// Response payload collector: writes data bytes into the response buffer
// while room remains, counts captured bytes and flags dropped ones.
module tblink_rpc_rsp_deser
   import tblink_rpc_cmd_pkg::*;
#(
   parameter int CMD_RSP_SZ = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clr_i,
   input  logic                    wr_i,
   input  logic [7:0]              dat_i,
   output logic [CMD_RSP_SZ*8-1:0] rsp_o,
   output logic [7:0]              rsp_sz_o,
   output logic [7:0]              idx_o,
   output logic                    ovf_o
);

   localparam logic [7:0] RSP_MAX = 8'(CMD_RSP_SZ);

   logic [CMD_RSP_SZ*8-1:0] rsp_q, rsp_d;
   logic [7:0]              sz_q, sz_d, idx_q, idx_d;

   always_comb begin
      rsp_d = rsp_q;
      sz_d  = sz_q;
      idx_d = idx_q;
      if (clr_i) begin
         rsp_d = '0;
         sz_d  = '0;
         idx_d = '0;
      end else if (wr_i) begin
         for (int i = 0; i < CMD_RSP_SZ; i++)
            if (idx_q == 8'(i)) rsp_d[i*8 +: 8] = dat_i;
         if (sz_q < RSP_MAX) sz_d = sz_q + 8'd1;
         idx_d = idx_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_q <= '0;
         sz_q  <= '0;
         idx_q <= '0;
      end else begin
         rsp_q <= rsp_d;
         sz_q  <= sz_d;
         idx_q <= idx_d;
      end
   end

   assign rsp_o    = rsp_q;
   assign rsp_sz_o = sz_q;
   assign idx_o    = idx_q;
   assign ovf_o    = wr_i && (idx_q >= RSP_MAX);

endmodule

// File: rtl/tblink_rpc_cmdsender.sv
// Initiator-side command sender: serializes one command from the put/get
// slot as a tblink packet, then collects the response and toggles get.
module tblink_rpc_cmdsender
   import tblink_rpc_cmd_pkg::*;
#(
   parameter int ADDR          = 1,
   parameter int CMD_PARAMS_SZ = 4,
   parameter int CMD_RSP_SZ    = 1,
   parameter int TIMEOUT       = 1024
) (
   input  logic                       uclock,
   input  logic                       reset,
   input  logic [7:0]                 cmd,
   input  logic [7:0]                 cmd_sz,
   input  logic [CMD_PARAMS_SZ*8-1:0] cmd_params,
   input  logic                       cmd_put_i,
   output logic                       cmd_get_i,
   output logic [CMD_RSP_SZ*8-1:0]    cmd_rsp,
   output logic [7:0]                 cmd_rsp_sz,
   output logic [1:0]                 cmd_status,
   output logic [7:0]                 pkto_dat,
   output logic                       pkto_valid,
   input  logic                       pkto_ready,
   input  logic [7:0]                 pkti_dat,
   input  logic                       pkti_valid,
   output logic                       pkti_ready
);

   localparam int         TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);
   localparam logic [7:0] PSZ    = 8'(CMD_PARAMS_SZ);

   logic [3:0]                 state_q, state_d;
   logic                       get_q, get_d;
   logic [1:0]                 stat_q, stat_d;
   logic                       vld_q, vld_d, rdy_q, rdy_d;
   logic [7:0]                 dat_q, dat_d;
   logic [7:0]                 cmd_q, cmd_d, n_q, n_d, idx_q, idx_d, len_q, len_d;
   logic [CMD_PARAMS_SZ*8-1:0] prm_q, prm_d;
   logic [TW-1:0]              to_q, to_d;
   logic                       tx_acc, rx_acc, clr, dwr, dovf;
   logic [7:0]                 didx;

   assign tx_acc = vld_q && pkto_ready;
   assign rx_acc = pkti_valid && rdy_q;

   always_comb begin
      state_d = state_q;
      get_d   = get_q;
      stat_d  = stat_q;
      vld_d   = vld_q;
      dat_d   = dat_q;
      cmd_d   = cmd_q;
      n_d     = n_q;
      idx_d   = idx_q;
      len_d   = len_q;
      prm_d   = prm_q;
      to_d    = to_q;
      clr     = 1'b0;
      dwr     = 1'b0;
      case (state_q)
         ST_IDLE: if (cmd_put_i != get_q) begin
            cmd_d   = cmd;
            n_d     = (cmd_sz > PSZ) ? PSZ : cmd_sz;
            prm_d   = cmd_params;
            stat_d  = (cmd_sz > PSZ) ? STAT_OVF : STAT_OK;
            to_d    = '0;
            clr     = 1'b1;
            vld_d   = 1'b1;
            dat_d   = 8'(ADDR);
            state_d = ST_TX_ADDR;
         end
         ST_TX_ADDR: if (tx_acc) begin
            dat_d   = n_q + 8'd1;
            state_d = ST_TX_LEN;
         end
         ST_TX_LEN: if (tx_acc) begin
            dat_d   = cmd_q;
            state_d = ST_TX_CMD;
         end
         ST_TX_CMD: if (tx_acc) begin
            idx_d = '0;
            if (n_q != 8'd0) begin
               dat_d   = prm_q[7:0];
               state_d = ST_TX_PARAM;
            end else begin
               vld_d   = 1'b0;
               state_d = ST_RX_ADDR;
            end
         end
         ST_TX_PARAM: if (tx_acc) begin
            if (idx_q == n_q - 8'd1) begin
               vld_d   = 1'b0;
               state_d = ST_RX_ADDR;
            end else begin
               idx_d = idx_q + 8'd1;
               for (int i = 0; i < CMD_PARAMS_SZ; i++)
                  if (idx_d == 8'(i)) dat_d = prm_q[i*8 +: 8];
            end
         end
         ST_RX_ADDR: begin
            // A byte arriving on the final count still wins over the timeout.
            if (rx_acc) state_d = ST_RX_LEN;
            else if (TIMEOUT != 0 && to_q == TO_MAX) begin
               stat_d  = stat_merge(stat_q, STAT_TIMEOUT);
               state_d = ST_DONE;
            end else to_d = to_q + 1'b1;
         end
         ST_RX_LEN: if (rx_acc) begin
            len_d = pkti_dat;
            if (pkti_dat == 8'd0) begin
               stat_d  = stat_merge(stat_q, STAT_MISMATCH);
               state_d = ST_DONE;
            end else state_d = ST_RX_CMD;
         end
         ST_RX_CMD: if (rx_acc) begin
            if (pkti_dat != cmd_q) stat_d = stat_merge(stat_q, STAT_MISMATCH);
            state_d = (len_q == 8'd1) ? ST_DONE : ST_RX_DATA;
         end
         ST_RX_DATA: if (rx_acc) begin
            dwr = 1'b1;
            if (dovf) stat_d = stat_merge(stat_q, STAT_OVF);
            if (didx + 8'd1 == len_q - 8'd1) state_d = ST_DONE;
         end
         ST_DONE: begin
            get_d   = ~get_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      rdy_d = (state_d == ST_IDLE) || (state_d >= ST_RX_ADDR && state_d <= ST_RX_DATA);
   end

   always_ff @(posedge uclock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         get_q   <= 1'b0;
         stat_q  <= STAT_OK;
         vld_q   <= 1'b0;
         rdy_q   <= 1'b0;
         dat_q   <= '0;
         cmd_q   <= '0;
         n_q     <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         prm_q   <= '0;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         get_q   <= get_d;
         stat_q  <= stat_d;
         vld_q   <= vld_d;
         rdy_q   <= rdy_d;
         dat_q   <= dat_d;
         cmd_q   <= cmd_d;
         n_q     <= n_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         prm_q   <= prm_d;
         to_q    <= to_d;
      end
   end

   tblink_rpc_rsp_deser #(.CMD_RSP_SZ(CMD_RSP_SZ)) u_deser (
      .clk_i    (uclock),
      .rst_ni   (reset),
      .clr_i    (clr),
      .wr_i     (dwr),
      .dat_i    (pkti_dat),
      .rsp_o    (cmd_rsp),
      .rsp_sz_o (cmd_rsp_sz),
      .idx_o    (didx),
      .ovf_o    (dovf)
   );

   assign cmd_get_i  = get_q;
   assign cmd_status = stat_q;
   assign pkto_dat   = dat_q;
   assign pkto_valid = vld_q;
   assign pkti_ready = rdy_q;

endmodule

// File: tb/tb_tblink_rpc_cmdsender.sv
// Directed table-driven bench for tblink_rpc_cmdsender with TIMEOUT=16.
module tb_tblink_rpc_cmdsender;

   localparam int TO = 16;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [7:0]  cmd = '0, cmd_sz = '0;
   logic [31:0] cmd_params = '0;
   logic        cmd_put = 1'b0, cmd_get;
   logic [7:0]  cmd_rsp, cmd_rsp_sz, pkto_dat, pkti_dat = '0;
   logic [1:0]  cmd_status;
   logic        pkto_valid, pkto_ready = 1'b1, pkti_valid = 1'b0, pkti_ready;

   int n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   tblink_rpc_cmdsender #(.ADDR(1), .CMD_PARAMS_SZ(4), .CMD_RSP_SZ(1), .TIMEOUT(TO)) dut (
      .uclock(clk), .reset(rst_n), .cmd(cmd), .cmd_sz(cmd_sz), .cmd_params(cmd_params),
      .cmd_put_i(cmd_put), .cmd_get_i(cmd_get), .cmd_rsp(cmd_rsp), .cmd_rsp_sz(cmd_rsp_sz),
      .cmd_status(cmd_status), .pkto_dat(pkto_dat), .pkto_valid(pkto_valid),
      .pkto_ready(pkto_ready), .pkti_dat(pkti_dat), .pkti_valid(pkti_valid),
      .pkti_ready(pkti_ready));

   // tx/rx byte 0 sits in bits [7:0]
   typedef struct packed {
      logic [7:0]  cmd, sz;
      logic [31:0] prm;
      logic [3:0]  ntx;
      logic [63:0] tx;
      logic [3:0]  nrx;
      logic [47:0] rx;
      logic [7:0]  rsp, rsz;
      logic [1:0]  st;
      logic        stall;
   } vec_t;

   vec_t tv[8];
   vec_t vr;

   function automatic vec_t mk(logic [7:0] c, logic [7:0] s, logic [31:0] p, logic [3:0] ntx,
                               logic [63:0] tx, logic [3:0] nrx, logic [47:0] rx,
                               logic [7:0] rsp, logic [7:0] rsz, logic [1:0] st, logic stall);
      vec_t v;
      v.cmd = c; v.sz = s; v.prm = p; v.ntx = ntx; v.tx = tx; v.nrx = nrx; v.rx = rx;
      v.rsp = rsp; v.rsz = rsz; v.st = st; v.stall = stall;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic run_txn(input vec_t v, input bit do_toggle, input string nm);
      int ntx, nrx, cyc, last_tx, d;
      logic g0, txf, rxf;
      logic [7:0] txb;
      bit done;
      g0 = cmd_get;
      cmd = v.cmd; cmd_sz = v.sz; cmd_params = v.prm;
      if (do_toggle) cmd_put = ~cmd_put;
      ntx = 0; nrx = 0; cyc = 0; last_tx = 0; done = 0;
      while (!done && cyc < 400) begin
         pkto_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (ntx >= int'(v.ntx) && nrx < int'(v.nrx) && (!v.stall || $urandom_range(0, 2) != 0)) begin
            pkti_valid = 1'b1;
            pkti_dat   = v.rx[nrx*8 +: 8];
         end else begin
            pkti_valid = 1'b0;
            pkti_dat   = 8'hEE;
         end
         txf = pkto_valid && pkto_ready;
         txb = pkto_dat;
         rxf = pkti_valid && pkti_ready;
         @(posedge clk);
         cyc++;
         if (txf) begin
            if (ntx < int'(v.ntx)) chk({nm, "_tx_byte"}, {24'd0, txb}, {24'd0, v.tx[ntx*8 +: 8]});
            ntx++;
            last_tx = cyc;
         end
         if (rxf) nrx++;
         @(negedge clk);
         if (cmd_get != g0) done = 1;
      end
      pkti_valid = 1'b0;
      pkto_ready = 1'b1;
      chk({nm, "_get_toggled"}, {31'd0, cmd_get}, {31'd0, ~g0});
      chk({nm, "_tx_count"}, ntx, {28'd0, v.ntx});
      chk({nm, "_rx_count"}, nrx, {28'd0, v.nrx});
      chk({nm, "_rsp"}, {24'd0, cmd_rsp}, {24'd0, v.rsp});
      chk({nm, "_rsp_sz"}, {24'd0, cmd_rsp_sz}, {24'd0, v.rsz});
      chk({nm, "_status"}, {30'd0, cmd_status}, {30'd0, v.st});
      if (v.nrx == 4'd0) begin
         // 16 cycles counting in RX_ADDR, plus at most one for DONE
         d = cyc - last_tx;
         n_cmp++;
         if (d < TO || d > TO + 1) begin
            n_bad++;
            $display("FAIL %s_timeout_latency: got %0d want %0d..%0d", nm, d, TO, TO + 1);
         end
      end
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_get"}, {31'd0, cmd_get}, 32'd0);
      chk({nm, "_pkto_valid"}, {31'd0, pkto_valid}, 32'd0);
      chk({nm, "_pkti_ready"}, {31'd0, pkti_ready}, 32'd0);
      chk({nm, "_rsp"}, {24'd0, cmd_rsp}, 32'd0);
      chk({nm, "_rsp_sz"}, {24'd0, cmd_rsp_sz}, 32'd0);
      chk({nm, "_status"}, {30'd0, cmd_status}, 32'd0);
   endtask

   initial begin
      tv[0] = mk(8'h05, 8'd2, 32'h0000BBAA, 4'd5, 64'h000000BBAA050301, 4'd4, 48'h00007E050209, 8'h7E, 8'd1, 2'd0, 1'b0);
      tv[1] = mk(8'h05, 8'd2, 32'h0000BBAA, 4'd5, 64'h000000BBAA050301, 4'd4, 48'h00007E050209, 8'h7E, 8'd1, 2'd0, 1'b1);
      tv[2] = mk(8'h05, 8'd6, 32'hDDCCBBAA, 4'd7, 64'h00DDCCBBAA050501, 4'd5, 48'h002211050301, 8'h11, 8'd1, 2'd1, 1'b0);
      tv[3] = mk(8'h05, 8'd0, 32'h00000000, 4'd3, 64'h0000000000050101, 4'd4, 48'h000033060201, 8'h33, 8'd1, 2'd2, 1'b0);
      tv[4] = mk(8'h5A, 8'd1, 32'h000000C3, 4'd4, 64'h00000000C35A0201, 4'd3, 48'h0000005A0102, 8'h00, 8'd0, 2'd0, 1'b0);
      tv[5] = mk(8'h07, 8'd0, 32'h00000000, 4'd3, 64'h0000000000070101, 4'd2, 48'h000000000003, 8'h00, 8'd0, 2'd2, 1'b0);
      tv[6] = mk(8'h09, 8'd1, 32'h00000044, 4'd4, 64'h0000000044090201, 4'd0, 48'h000000000000, 8'h00, 8'd0, 2'd3, 1'b0);
      tv[7] = mk(8'h21, 8'd4, 32'h04030201, 4'd7, 64'h0004030201210501, 4'd5, 48'h00809F210301, 8'h9F, 8'd1, 2'd1, 1'b1);
      vr    = mk(8'h30, 8'd3, 32'h00CCBBAA, 4'd6, 64'h0000CCBBAA300401, 4'd4, 48'h000055300201, 8'h55, 8'd1, 2'd0, 1'b0);

      repeat (2) @(negedge clk);
      chk_reset_vals("reset0");
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) run_txn(tv[i], 1'b1, $sformatf("v%0d", i));

      run_txn(tv[6], 1'b1, "v6");

      // stray packet while idle must be swallowed without side effects
      for (int i = 0; i < 3; i++) begin
         pkti_valid = 1'b1;
         pkti_dat   = 8'(8'h40 + i);
         chk("stray_ready", {31'd0, pkti_ready}, 32'd1);
         @(posedge clk);
         @(negedge clk);
      end
      pkti_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("stray_get", {31'd0, cmd_get}, {31'd0, cmd_put});
      chk("stray_pkto_valid", {31'd0, pkto_valid}, 32'd0);

      run_txn(tv[7], 1'b1, "v7");

      // reset with a completed response held, then with a packet mid-flight
      rst_n = 1'b0;
      cmd_put = 1'b0;
      @(negedge clk);
      chk_reset_vals("reset1");
      rst_n = 1'b1;
      @(negedge clk);
      cmd = vr.cmd; cmd_sz = vr.sz; cmd_params = vr.prm;
      cmd_put = 1'b1;
      repeat (5) @(negedge clk);
      chk("mid_pkto_valid", {31'd0, pkto_valid}, 32'd1);
      chk("mid_pkto_dat", {24'd0, pkto_dat}, 32'hBB);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_pkto_valid", {31'd0, pkto_valid}, 32'd0);
      chk("mid_rst_get", {31'd0, cmd_get}, 32'd0);
      rst_n = 1'b1;
      run_txn(vr, 1'b0, "resend");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
